score_keeper: RTL and testbench

Game-statistics engine sitting directly upstream of the seven-segment display driver. Consumes one-cycle hit/miss note-judgement pulses from the note-timing logic and maintains:
- running score, with a combo multiplier
- level and scroll speed
- remaining lives

Produces the `score`, `speed` and `level` buses the display driver renders; all three are bounded so they always fit its 4-digit and 2-digit fields.

---
 rtl/score_keeper.sv | 152 +++++++++++++++
 tb/tb_score_keeper.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// Game-statistics engine: score with combo multiplier, level/speed progression and lives.
// Define SCORE_KEEPER_LIVES_EN to track lives and allow the OVER state.
module score_keeper #(
   parameter int unsigned POINTS_PER_HIT = 10,
   parameter int unsigned COMBO_PER_MULT = 8,
   parameter int unsigned MAX_MULT       = 4,
   parameter int unsigned HITS_PER_LEVEL = 16,
   parameter int unsigned BASE_SPEED     = 10,
   parameter int unsigned SPEED_STEP     = 5,
   parameter int unsigned MAX_SPEED      = 99,
   parameter int unsigned MAX_LEVEL      = 99,
   parameter int unsigned SCORE_MAX      = 9999,
   parameter int unsigned START_LIVES    = 3
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        start_in,
   input  logic        pause_in,
   input  logic        hit_in,
   input  logic        miss_in,
   output logic [31:0] score,
   output logic [13:0] speed,
   output logic [13:0] level,
   output logic [13:0] combo,
   output logic [3:0]  lives_out,
   output logic        playing,
   output logic        game_over
);

   typedef enum logic [1:0] {StIdle, StPlay, StPause, StOver} state_e;

   localparam logic [13:0] ComboSat = 14'h3fff;

   state_e      state_q, state_d;
   logic [31:0] score_q, score_d;
   logic [13:0] combo_q, combo_d;
   logic [13:0] level_q, level_d;
   logic [13:0] speed_q, speed_d;
   logic [15:0] lvl_cnt_q, lvl_cnt_d;

   logic [31:0] mult_idx;
   logic [31:0] points;
   logic [32:0] sum;
   logic [31:0] spd_next;
   logic        act;

`ifdef SCORE_KEEPER_LIVES_EN
   logic [3:0] lives_q, lives_d;
`endif

   always_comb begin
      state_d   = state_q;
      score_d   = score_q;
      combo_d   = combo_q;
      level_d   = level_q;
      speed_d   = speed_q;
      lvl_cnt_d = lvl_cnt_q;
`ifdef SCORE_KEEPER_LIVES_EN
      lives_d   = lives_q;
`endif

      // Multiplier uses the combo before this hit's increment.
      mult_idx = 32'(combo_q) / COMBO_PER_MULT;
      if (mult_idx > MAX_MULT - 1) mult_idx = MAX_MULT - 1;
      points   = POINTS_PER_HIT * (mult_idx + 32'd1);
      sum      = {1'b0, score_q} + {1'b0, points};
      spd_next = 32'(speed_q) + SPEED_STEP;

      // Judgements are dropped on the cycle that leaves PLAY for PAUSE.
      act = (state_q == StPlay) && !pause_in;

      unique case (state_q)
         StIdle, StOver: begin
            if (start_in) begin
               state_d   = StPlay;
               score_d   = '0;
               combo_d   = '0;
               lvl_cnt_d = '0;
               level_d   = 14'd1;
               speed_d   = 14'(BASE_SPEED);
`ifdef SCORE_KEEPER_LIVES_EN
               lives_d   = 4'(START_LIVES);
`endif
            end
         end
         StPlay:  if (pause_in) state_d = StPause;
         StPause: if (!pause_in) state_d = StPlay;
         default: state_d = StIdle;
      endcase

      if (act && hit_in) begin
         score_d = (sum > 33'(SCORE_MAX)) ? SCORE_MAX : sum[31:0];
         if (combo_q != ComboSat) combo_d = combo_q + 14'd1;
         if (32'(lvl_cnt_q) + 32'd1 >= HITS_PER_LEVEL) begin
            lvl_cnt_d = '0;
            if (32'(level_q) < MAX_LEVEL) begin
               level_d = level_q + 14'd1;
               speed_d = (spd_next > MAX_SPEED) ? 14'(MAX_SPEED) : spd_next[13:0];
            end
         end else begin
            lvl_cnt_d = lvl_cnt_q + 16'd1;
         end
      end

      // Miss after hit so a simultaneous pair scores first, then clears the combo.
      if (act && miss_in) begin
         combo_d = '0;
`ifdef SCORE_KEEPER_LIVES_EN
         if (lives_q != 4'd0) lives_d = lives_q - 4'd1;
         if (lives_q <= 4'd1) state_d = StOver;
`endif
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q   <= StIdle;
         score_q   <= '0;
         combo_q   <= '0;
         level_q   <= 14'd1;
         speed_q   <= 14'(BASE_SPEED);
         lvl_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         score_q   <= score_d;
         combo_q   <= combo_d;
         level_q   <= level_d;
         speed_q   <= speed_d;
         lvl_cnt_q <= lvl_cnt_d;
      end
   end

`ifdef SCORE_KEEPER_LIVES_EN
   always_ff @(posedge clk_in) begin
      if (rst_in) lives_q <= 4'(START_LIVES);
      else        lives_q <= lives_d;
   end

   assign lives_out = lives_q;
   assign game_over = (state_q == StOver);
`else
   assign lives_out = '0;
   assign game_over = 1'b0;
`endif

   assign score   = score_q;
   assign combo   = combo_q;
   assign level   = level_q;
   assign speed   = speed_q;
   assign playing = (state_q == StPlay);

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper; a second instance with a small score ceiling checks saturation.
module tb_score_keeper;

   logic        clk_in = 1'b0;
   logic        rst_in, start_in, pause_in, hit_in, miss_in;
   logic [31:0] score, score_s;
   logic [13:0] speed, level, combo, speed_s, level_s, combo_s;
   logic [3:0]  lives_out, lives_s;
   logic        playing, game_over, playing_s, game_over_s;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef SCORE_KEEPER_LIVES_EN
   localparam int Lives3 = 3;
   localparam int Lives2 = 2;
   localparam bit LivesOn = 1'b1;
`else
   localparam int Lives3 = 0;
   localparam int Lives2 = 0;
   localparam bit LivesOn = 1'b0;
`endif

   always #5 clk_in = ~clk_in;

   score_keeper dut (
      .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .pause_in(pause_in),
      .hit_in(hit_in), .miss_in(miss_in), .score(score), .speed(speed), .level(level),
      .combo(combo), .lives_out(lives_out), .playing(playing), .game_over(game_over)
   );

   score_keeper #(.SCORE_MAX(95)) dut_sat (
      .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .pause_in(pause_in),
      .hit_in(hit_in), .miss_in(miss_in), .score(score_s), .speed(speed_s), .level(level_s),
      .combo(combo_s), .lives_out(lives_s), .playing(playing_s), .game_over(game_over_s)
   );

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic hits(input int n);
      hit_in = 1'b1;
      repeat (n) tick();
      hit_in = 1'b0;
   endtask

   task automatic do_reset_start();
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
   endtask

   initial begin
      rst_in = 1'b1; start_in = 1'b0; pause_in = 1'b0; hit_in = 1'b0; miss_in = 1'b0;
      tick();
      rst_in = 1'b0;
      check("rst_score", score, 0);
      check("rst_combo", 32'(combo), 0);
      check("rst_level", 32'(level), 1);
      check("rst_speed", 32'(speed), 10);
      check("rst_lives", 32'(lives_out), Lives3);
      check("rst_playing", 32'(playing), 0);
      check("rst_over", 32'(game_over), 0);

      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      check("start_playing", 32'(playing), 1);

      // 8 hits at x1, then x2 from combo 8
      hits(8);
      check("h8_score", score, 80);
      check("h8_combo", 32'(combo), 8);
      check("h8_sat_score", score_s, 80);
      hits(1);
      check("h9_score", score, 100);
      check("h9_sat_score", score_s, 95);
      hits(1);
      check("h10_sat_hold", score_s, 95);
      check("h10_score", score, 120);
      check("h10_level", 32'(level), 1);
      hits(6);
      check("h16_score", score, 240);
      check("h16_level", 32'(level), 2);
      check("h16_speed", 32'(speed), 15);
      check("h16_combo", 32'(combo), 16);

      // simultaneous hit+miss at combo 8
      do_reset_start();
      hits(8);
      hit_in = 1'b1; miss_in = 1'b1;
      tick();
      hit_in = 1'b0; miss_in = 1'b0;
      check("hm_score", score, 100);
      check("hm_combo", 32'(combo), 0);
      check("hm_lives", 32'(lives_out), Lives2);

      // two more misses end the game when lives are tracked
      miss_in = 1'b1;
      repeat (2) tick();
      miss_in = 1'b0;
      check("m3_lives", 32'(lives_out), 0);
      check("m3_over", 32'(game_over), LivesOn ? 1 : 0);
      check("m3_playing", 32'(playing), LivesOn ? 0 : 1);
      hits(2);
      check("over_hits_score", score, LivesOn ? 100 : 120);
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      check("restart_score", score, LivesOn ? 0 : 120);
      check("restart_level", 32'(level), 1);
      check("restart_speed", 32'(speed), 10);
      check("restart_lives", 32'(lives_out), Lives3);
      check("restart_playing", 32'(playing), 1);
      check("restart_over", 32'(game_over), 0);

      // pause: hit on the pausing cycle and while paused are dropped
      do_reset_start();
      hits(1);
      check("p_pre_score", score, 10);
      pause_in = 1'b1; hit_in = 1'b1;
      tick();
      check("p_edge_score", score, 10);
      check("p_playing", 32'(playing), 0);
      repeat (4) tick();
      hit_in = 1'b0;
      check("p_score", score, 10);
      check("p_combo", 32'(combo), 1);
      check("p_over", 32'(game_over), 0);
      pause_in = 1'b0;
      tick();
      check("unp_playing", 32'(playing), 1);
      hits(1);
      check("unp_score", score, 20);
      check("unp_combo", 32'(combo), 2);
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      check("start_ign_score", score, 20);

      // reset wins over a concurrent hit
      rst_in = 1'b1; hit_in = 1'b1;
      tick();
      rst_in = 1'b0; hit_in = 1'b0;
      check("mrst_score", score, 0);
      check("mrst_combo", 32'(combo), 0);
      check("mrst_level", 32'(level), 1);
      check("mrst_speed", 32'(speed), 10);
      check("mrst_lives", 32'(lives_out), Lives3);
      check("mrst_playing", 32'(playing), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
